bit_serial_exec: RTL and testbench
==================================

# bit_serial_exec

Bit-serial execution unit of the CPU. It accepts one decoded instruction (4-bit opcode plus 12-bit operand word) from the instruction-load stage and executes it over eight clock cycles, LSB first, against four 8-bit shift-register GPRs. It drives the 8-bit result port that feeds the LED outputs. A one-bit ALU slice with a carry flip-flop does all arithmetic.

## Interface
Parameters:
- `WIDTH`, 8: register and datapath width; the bit counter spans 0..WIDTH-1.
- `NREG`, 4: number of GPRs; register index is 2 bits.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse meaning opcode/instr are complete and stable.
- `opcode`  in  4  operation.
- `instr`  in  12  operand word: [1:0]=rd, [3:2]=rs, [11:4]=imm8.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse, high in state DONE.
- `flag_z`  out  1  zero flag.
- `flag_c`  out  1  carry / not-borrow flag.
- `out`  out  8  result register, written only by OUT.

## Operation
- Reset (async): all GPRs, `out`, flags, carry FF, bit counter and imm copy are 0. State is IDLE, so `busy`=0 and `done`=0.
- States and transitions:
  - IDLE → EXEC on `start`. On that edge, latch opcode, rd, rs and imm8 into the imm shift copy.
  - Carry FF is initialised at the same time: 1 for SUB/CMP, 0 otherwise.
  - EXEC: 8 cycles, counter 0..7. At count 7 → DONE.
  - DONE: 1 cycle → IDLE.
- `start` is ignored outside IDLE, including during DONE.
- Every EXEC cycle, all GPRs rotate right one bit. rd's incoming MSB is replaced by the result bit for writing ops. After 8 cycles, all GPRs are back in original alignment. rd==rs is legal; the operand is read from bit 0 before the shift.
- Opcodes (result bit i). Z is set from the result on every flag-affecting op.
  - 0 NOP: no write, flags unchanged.
  - 1 LDI: rd←imm. Z updated, C unchanged.
  - 2 ADD: rd←rd+rs. C=carry out.
  - 3 SUB: rd←rd+~rs+1. C=1 means no borrow.
  - 4 AND, 5 OR, 6 XOR: rd←rd op rs. C←0.
  - 7 MOV: rd←rs. Z updated, C unchanged.
  - 8 ADDI: rd←rd+imm. C=carry out.
  - 9 SHL: bit i = rd[i-1], bit 0 = 0. C←old rd[7].
  - A SHR: bit i = rd[i+1] (read from shift position 1), bit 7 = 0. C←old rd[0].
  - B OUT: `out`←rd. No flag change.
  - C CMP: computes as SUB, no write, Z/C updated.
  - D–F: behave as NOP, full 8-cycle run, `done` pulses.
- Arithmetic is mod 256; overflow is not flagged.
- Z is accumulated as the OR of result bits during EXEC and committed inverted.

## Timing
- `start` is sampled at edge E0. Result bits shift at E1..E8.
- rd, `flag_z`, `flag_c` and `out` are updated at E8 (EXEC→DONE).
- `done`=1 between E8 and E9. IDLE is reached at E9.
- `busy`=1 from E0 to E9 (9 cycles). Back-to-back throughput is one instruction per 10 cycles. The earliest accepted next `start` is sampled at E10.
- Reset asserted mid-EXEC: all state is cleared immediately, with no partial writeback. `done` is not pulsed.
- Outputs are registered or decoded from registered state. No combinational path runs from `start` to any output.

## Structure
- Package `cpu_pkg` holds:
  - opcode localparams (OP_NOP..OP_CMP)
  - state encoding (IDLE, EXEC, DONE)
  - operand field positions (RD_LSB, RS_LSB, IMM_LSB)
  - `WIDTH` default
- Sub-module `serial_alu_slice`: a 1-bit datapath with inputs a, b, carry_in, op and outputs result bit and carry_out. The carry FF and sequencing stay in the parent.

## Test plan
- LDI r1,0x3C; then OUT r1 → `out`=0x3C at E8 of the OUT instruction, Z=0. `out` stays 0 before that.
- LDI r0,0xF0; LDI r1,0x20; ADD r0,r1 → r0=0x10, C=1, Z=0. Check via OUT r0: `out`=0x10.
- LDI r2,0x05; LDI r3,0x05; SUB r2,r3 → r2=0x00, Z=1, C=1. CMP r2,r3 with r2=0x04 → r2 unchanged (0x04), C=0, Z=0.
- LDI r0,0x81; SHL r0 → 0x02, C=1. Reload 0x81; SHR r0 → 0x40, C=1. ADD r1,r1 with r1=0x80 → 0x00, Z=1, C=1.
- Timing: `start` at E0 → `busy` high exactly 9 cycles, `done` a single pulse at E8–E9. A second `start` at E3 and at E9 is ignored: no register change.
- Reset: assert `rst_n`=0 at EXEC count 4 of ADD → `busy`=0, all GPRs/`out`/flags = 0 immediately. After release, LDI r0,0x55 then OUT r0 → `out`=0x55.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-serial CPU:
// opcodes, FSM states and operand field positions.
package cpu_pkg;

  localparam int WIDTH = 8;

  localparam int RD_LSB  = 0;
  localparam int RS_LSB  = 2;
  localparam int IMM_LSB = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice; the carry flop and bit
// sequencing live in the parent.
module serial_alu_slice
  import cpu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic [3:0] op,
  output logic       result,
  output logic       carry_out
);

  logic bx;
  logic is_sub;

  assign is_sub = (op == OP_SUB) || (op == OP_CMP);
  assign bx     = is_sub ? ~b : b;

  // Per-bit result and carry for the current op
  always_comb begin
    result    = 1'b0;
    carry_out = carry_in;
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_CMP: begin
        result    = a ^ bx ^ carry_in;
        carry_out = (a & bx) | (a & carry_in)
                  | (bx & carry_in);
      end
      OP_LDI, OP_MOV: result = b;
      OP_AND: begin
        result    = a & b;
        carry_out = 1'b0;
      end
      OP_OR: begin
        result    = a | b;
        carry_out = 1'b0;
      end
      OP_XOR: begin
        result    = a ^ b;
        carry_out = 1'b0;
      end
      OP_SHL: begin
        result    = carry_in;
        carry_out = a;
      end
      OP_SHR: begin
        result    = b;
        carry_out = carry_in;
      end
      OP_OUT: result = a;
      default: begin
        result    = 1'b0;
        carry_out = carry_in;
      end
    endcase
  end

endmodule

// File: rtl/bit_serial_exec.sv
// Bit-serial execution unit: one instruction
// over WIDTH cycles, LSB first, on shift GPRs.
module bit_serial_exec #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [11:0]      instr,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c,
  output logic [WIDTH-1:0] out
);

  import cpu_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(NREG);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [RW-1:0]    rd_q;
  logic [RW-1:0]    rs_q;
  logic [WIDTH-1:0] imm_sh;
  logic [WIDTH-2:0] res_sh;
  logic             carry_q;
  logic             z_acc;
  logic [WIDTH-1:0] gpr [NREG];

  logic wr_en;
  logic fz_en;
  logic fc_en;
  logic fc_clr;
  logic use_imm;
  logic is_shr;
  logic last;
  logic a_bit;
  logic b_bit;
  logic c_in;
  logic res;
  logic c_out;

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign last = (cnt == LAST);

  // Opcode class decode from the latched opcode
  always_comb begin
    wr_en   = 1'b0;
    fz_en   = 1'b0;
    fc_en   = 1'b0;
    fc_clr  = 1'b0;
    use_imm = 1'b0;
    is_shr  = 1'b0;
    unique case (1'b1)
      (op_q == OP_LDI): begin
        wr_en   = 1'b1;
        fz_en   = 1'b1;
        use_imm = 1'b1;
      end
      (op_q == OP_ADDI): begin
        wr_en   = 1'b1;
        fz_en   = 1'b1;
        fc_en   = 1'b1;
        use_imm = 1'b1;
      end
      (op_q == OP_ADD),
      (op_q == OP_SUB),
      (op_q == OP_SHL): begin
        wr_en = 1'b1;
        fz_en = 1'b1;
        fc_en = 1'b1;
      end
      (op_q == OP_SHR): begin
        wr_en  = 1'b1;
        fz_en  = 1'b1;
        fc_en  = 1'b1;
        is_shr = 1'b1;
      end
      (op_q == OP_AND),
      (op_q == OP_OR),
      (op_q == OP_XOR): begin
        wr_en  = 1'b1;
        fz_en  = 1'b1;
        fc_clr = 1'b1;
      end
      (op_q == OP_MOV): begin
        wr_en = 1'b1;
        fz_en = 1'b1;
      end
      (op_q == OP_CMP): begin
        fz_en = 1'b1;
        fc_en = 1'b1;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Operand bit select; SHR looks one ahead
  // and feeds a zero into the top bit
  always_comb begin
    a_bit = gpr[rd_q][0];
    unique case (1'b1)
      use_imm: b_bit = imm_sh[0];
      is_shr:  b_bit = last ? 1'b0
                            : gpr[rd_q][1];
      default: b_bit = gpr[rs_q][0];
    endcase
    c_in = (is_shr && cnt == '0) ? a_bit
                                 : carry_q;
  end

  serial_alu_slice u_alu (
    .a         (a_bit),
    .b         (b_bit),
    .carry_in  (c_in),
    .op        (op_q),
    .result    (res),
    .carry_out (c_out)
  );

  // Sequencer, GPR rotation and flag commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_sh  <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
      z_acc   <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      out     <= '0;
      for (int r = 0; r < NREG; r++)
        gpr[r] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= EXEC;
            cnt     <= '0;
            op_q    <= opcode;
            rd_q    <= instr[RD_LSB +: RW];
            rs_q    <= instr[RS_LSB +: RW];
            imm_sh  <= instr[IMM_LSB +: WIDTH];
            carry_q <= (opcode == OP_SUB) ||
                       (opcode == OP_CMP);
            z_acc   <= 1'b0;
          end
        end
        EXEC: begin
          for (int r = 0; r < NREG; r++) begin
            if (wr_en && r == int'(rd_q))
              gpr[r] <= {res, gpr[r][WIDTH-1:1]};
            else
              gpr[r] <= {gpr[r][0],
                         gpr[r][WIDTH-1:1]};
          end
          imm_sh  <= imm_sh >> 1;
          res_sh  <= {res, res_sh[WIDTH-2:1]};
          carry_q <= c_out;
          z_acc   <= z_acc | res;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            if (fz_en)
              flag_z <= ~(z_acc | res);
            if (fc_en)
              flag_c <= c_out;
            else if (fc_clr)
              flag_c <= 1'b0;
            if (op_q == OP_OUT)
              out <= {res, res_sh};
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_exec.sv
// Directed bench for bit_serial_exec with an
// expected-output queue for OUT results.
module tb_bit_serial_exec;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        busy;
  logic        done;
  logic        flag_z;
  logic        flag_c;
  logic [7:0]  out;

  int vecs = 0;
  int errs = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  bit_serial_exec #(.WIDTH(8), .NREG(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .opcode (opcode),
    .instr  (instr),
    .busy   (busy),
    .done   (done),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .out    (out)
  );

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run(logic [3:0] op,
                     logic [1:0] rd,
                     logic [1:0] rs,
                     logic [7:0] imm);
    int n;
    logic [7:0] e;
    @(negedge clk);
    opcode = op;
    instr  = {imm, rs, rd};
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    if (op == OP_OUT) begin
      e = exp_q.pop_front();
      chk("out_sb", {24'b0, out}, {24'b0, e});
    end
    @(negedge clk);
  endtask

  task automatic outp(logic [1:0] rd,
                      logic [7:0] e);
    exp_q.push_back(e);
    run(OP_OUT, rd, 2'd0, 8'h00);
  endtask

  task automatic flags(string tag,
                       logic z, logic c);
    chk({tag, "_z"}, {31'b0, flag_z}, {31'b0, z});
    chk({tag, "_c"}, {31'b0, flag_c}, {31'b0, c});
  endtask

  initial begin
    int bcnt;
    int dcnt;
    int dpos;
    int k;
    rst_n  = 1'b0;
    start  = 1'b0;
    opcode = 4'h0;
    instr  = 12'h000;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_out", {24'b0, out}, 32'd0);
    flags("rst", 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(OP_LDI, 2'd1, 2'd0, 8'h3C);
    chk("out_before", {24'b0, out}, 32'd0);
    chk("ldi_z", {31'b0, flag_z}, 32'd0);
    outp(2'd1, 8'h3C);

    run(OP_LDI, 2'd0, 2'd0, 8'hF0);
    run(OP_LDI, 2'd1, 2'd0, 8'h20);
    run(OP_ADD, 2'd0, 2'd1, 8'h00);
    flags("add", 1'b0, 1'b1);
    outp(2'd0, 8'h10);

    run(OP_LDI, 2'd2, 2'd0, 8'h05);
    run(OP_LDI, 2'd3, 2'd0, 8'h05);
    run(OP_SUB, 2'd2, 2'd3, 8'h00);
    flags("sub", 1'b1, 1'b1);
    outp(2'd2, 8'h00);
    run(OP_LDI, 2'd2, 2'd0, 8'h04);
    run(OP_CMP, 2'd2, 2'd3, 8'h00);
    flags("cmp", 1'b0, 1'b0);
    outp(2'd2, 8'h04);

    run(OP_LDI, 2'd0, 2'd0, 8'h81);
    run(OP_SHL, 2'd0, 2'd0, 8'h00);
    flags("shl", 1'b0, 1'b1);
    outp(2'd0, 8'h02);
    run(OP_LDI, 2'd0, 2'd0, 8'h81);
    run(OP_SHR, 2'd0, 2'd0, 8'h00);
    flags("shr", 1'b0, 1'b1);
    outp(2'd0, 8'h40);
    run(OP_LDI, 2'd1, 2'd0, 8'h80);
    run(OP_ADD, 2'd1, 2'd1, 8'h00);
    flags("add_self", 1'b1, 1'b1);
    outp(2'd1, 8'h00);

    @(negedge clk);
    opcode = OP_NOP;
    instr  = 12'h000;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    dcnt = 0;
    dpos = 0;
    k = 1;
    while (busy === 1'b1 && k < 30) begin
      bcnt++;
      if (done === 1'b1) begin
        dcnt++;
        dpos = k;
      end
      if (k == 3 || k == 9) begin
        opcode = OP_LDI;
        instr  = {8'hAA, 2'd0, 2'd2};
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("busy_len", bcnt, 32'd9);
    chk("done_cnt", dcnt, 32'd1);
    chk("done_pos", dpos, 32'd9);
    chk("idle_after", {31'b0, busy}, 32'd0);
    flags("nop", 1'b1, 1'b1);
    outp(2'd2, 8'h04);

    @(negedge clk);
    opcode = OP_ADD;
    instr  = {8'h00, 2'd3, 2'd3};
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_done", {31'b0, done}, 32'd0);
    chk("mid_out", {24'b0, out}, 32'd0);
    flags("mid", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    outp(2'd3, 8'h00);
    outp(2'd2, 8'h00);
    run(OP_LDI, 2'd0, 2'd0, 8'h55);
    outp(2'd0, 8'h55);

    run(OP_LDI, 2'd1, 2'd0, 8'hFF);
    run(OP_LDI, 2'd2, 2'd0, 8'h01);
    run(OP_ADD, 2'd2, 2'd1, 8'h00);
    flags("add_wrap", 1'b1, 1'b1);
    run(OP_XOR, 2'd1, 2'd1, 8'h00);
    flags("xor", 1'b1, 1'b0);
    run(4'hE, 2'd1, 2'd0, 8'hFF);
    outp(2'd1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
